char_line_drawer: RTL and testbench

- Downstream consumer of the codebreaker's display outputs. When the codebreaker raises dpt, this block latches the 128-bit plaintext as 16 ASCII characters and renders them as a single line of 8x16 glyphs.
- Glyph rows come from an external registered font ROM. Pixel writes go to the bitmap/VGA frame buffer through a valid/ready write port.
- Raises ddpt when the whole line is drawn.

---
 rtl/char_line_drawer.sv | 172 +++++++++++++++++
 tb/tb_char_line_drawer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_line_drawer.sv
// Renders a latched 16-character plaintext line as 8x16 glyphs into a frame buffer write port.
// Optional macro CHAR_LINE_DRAWER_TRANSPARENT_EN: skip background pixels instead of writing them.
module char_line_drawer #(
    parameter int                   X0       = 96,
    parameter int                   Y0       = 112,
    parameter int                   X_W      = 9,
    parameter int                   Y_W      = 8,
    parameter int                   COLOR_W  = 3,
    parameter logic [COLOR_W-1:0]   FG_COLOR = 3'b111,
    parameter logic [COLOR_W-1:0]   BG_COLOR = 3'b000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                dpt,
    input  logic [127:0]        plaintext,
    output logic                ddpt,
    output logic                busy,
    output logic [11:0]         font_addr,
    input  logic [7:0]          font_data,
    output logic                wr_en,
    input  logic                wr_ready,
    output logic [X_W-1:0]      wr_x,
    output logic [Y_W-1:0]      wr_y,
    output logic [COLOR_W-1:0]  wr_color
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [127:0]         text_q, text_d;
    logic [3:0]           char_idx_q, char_idx_d;
    logic [3:0]           row_q, row_d;
    logic [2:0]           col_q, col_d;
    logic [7:0]           glyph_q, glyph_d;
    logic                 wr_en_q, wr_en_d;
    logic [X_W-1:0]       wr_x_q, wr_x_d;
    logic [Y_W-1:0]       wr_y_q, wr_y_d;
    logic [COLOR_W-1:0]   wr_color_q, wr_color_d;
    logic                 ddpt_q, ddpt_d;
    logic                 busy_q, busy_d;
    logic [6:0]           text_sel_s;
    logic                 advance_s;

    // Character 0 sits in the top byte, so the byte offset is (15 - char_idx) * 8.
    assign text_sel_s = {~char_idx_q, 3'b000};
    assign font_addr  = {text_q[text_sel_s +: 8], row_q};

`ifdef CHAR_LINE_DRAWER_TRANSPARENT_EN
    assign advance_s = wr_ready || !glyph_q[7];
`else
    assign advance_s = wr_ready;
`endif

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        text_d     = text_q;
        char_idx_d = char_idx_q;
        row_d      = row_q;
        col_d      = col_q;
        glyph_d    = glyph_q;
        case (state_q)
            S_IDLE: begin
                if (dpt) begin
                    text_d     = plaintext;
                    char_idx_d = 4'd0;
                    row_d      = 4'd0;
                    col_d      = 3'd0;
                    state_d    = S_FETCH;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                glyph_d = font_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (advance_s) begin
                    // The current pixel is always glyph bit 7; shift the next one in.
                    glyph_d = {glyph_q[6:0], 1'b0};
                    col_d   = col_q + 3'd1;
                    if (col_q == 3'd7) begin
                        row_d = row_q + 4'd1;
                        if (row_q == 4'd15) begin
                            char_idx_d = char_idx_q + 4'd1;
                            state_d    = (char_idx_q == 4'd15) ? S_DONE : S_FETCH;
                        end else begin
                            state_d    = S_FETCH;
                        end
                    end else begin
                        state_d = S_WRITE;
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE: begin
                if (!dpt) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_WRITE) begin
            wr_x_d     = X_W'(X0) + X_W'({char_idx_d, col_d});
            wr_y_d     = Y_W'(Y0) + Y_W'(row_d);
            wr_color_d = glyph_d[7] ? FG_COLOR : BG_COLOR;
`ifdef CHAR_LINE_DRAWER_TRANSPARENT_EN
            wr_en_d    = glyph_d[7];
`else
            wr_en_d    = 1'b1;
`endif
        end else begin
            wr_x_d     = '0;
            wr_y_d     = '0;
            wr_color_d = '0;
            wr_en_d    = 1'b0;
        end
        ddpt_d = (state_d == S_DONE);
        busy_d = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_WRITE);
    end

    // State, counters, text latch and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            text_q     <= '0;
            char_idx_q <= 4'd0;
            row_q      <= 4'd0;
            col_q      <= 3'd0;
            glyph_q    <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_color_q <= '0;
            ddpt_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            text_q     <= text_d;
            char_idx_q <= char_idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            glyph_q    <= glyph_d;
            wr_en_q    <= wr_en_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_color_q <= wr_color_d;
            ddpt_q     <= ddpt_d;
            busy_q     <= busy_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_x     = wr_x_q;
    assign wr_y     = wr_y_q;
    assign wr_color = wr_color_q;
    assign ddpt     = ddpt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_char_line_drawer.sv
// Directed self-checking bench for char_line_drawer with a registered font ROM model.
module tb_char_line_drawer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         dpt = 1'b0;
    logic [127:0] plaintext = '0;
    logic         ddpt, busy, wr_en;
    logic         wr_ready = 1'b1;
    logic [11:0]  font_addr;
    logic [7:0]   font_data;
    logic [8:0]   wr_x;
    logic [7:0]   wr_y;
    logic [2:0]   wr_color;

    int n_cmp = 0;
    int n_mism = 0;

    int n_wr = 0;
    int wr_bad = 0;
    int n_413 = 0;
    int n_row3 = 0;
    int draw_wr = 0;
    logic [19:0] first_w = '0;
    logic [19:0] last_w = '0;
    logic [2:0]  row3_col [8];
    logic [19:0] exp_q [$];

    char_line_drawer dut (
        .clk(clk), .reset_n(reset_n), .dpt(dpt), .plaintext(plaintext),
        .ddpt(ddpt), .busy(busy), .font_addr(font_addr), .font_data(font_data),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color)
    );

    always #5 clk = ~clk;

    // Glyph table: space is blank, 'A' has 40 set bits with row 3 = 8'h81.
    function automatic logic [7:0] rom_f(input logic [11:0] a);
        if (a[11:4] == 8'h20) return 8'h00;
        if (a[11:4] == 8'h41) begin
            case (a[3:0])
                4'd1:  return 8'h18;
                4'd2:  return 8'h24;
                4'd6:  return 8'hFF;
                4'd11: return 8'hC3;
                4'd12: return 8'hC3;
                4'd15: return 8'h00;
                default: return 8'h81;
            endcase
        end
        return {a[7:4], a[3:0]};
    endfunction

    always @(posedge clk) font_data <= rom_f(font_addr);

    // Write monitor: counts accepted writes and checks them against the expected pixel list.
    always @(negedge clk) begin
        logic [19:0] act;
        logic [19:0] e;
        if (reset_n) begin
            if (font_addr == 12'h413) n_413++;
            if (!busy) draw_wr = 0;
            if (wr_en && wr_ready) begin
                act = {wr_x, wr_y, wr_color};
                n_wr++;
                if (draw_wr == 0) first_w = act;
                draw_wr++;
                last_w = act;
                if (exp_q.size() == 0) begin
                    wr_bad++;
                end else begin
                    e = exp_q.pop_front();
                    if (e !== act) wr_bad++;
                end
                if (wr_y == 8'd115 && wr_x >= 9'd96 && wr_x <= 9'd103) begin
                    row3_col[wr_x - 9'd96] = wr_color;
                    n_row3++;
                end
            end
        end
    end

    task automatic build_exp(input logic [127:0] txt);
        logic [7:0] ch;
        logic [7:0] g;
        exp_q.delete();
        for (int c = 0; c < 16; c++) begin
            ch = txt[127 - 8*c -: 8];
            for (int r = 0; r < 16; r++) begin
                g = rom_f({ch, 4'(r)});
                for (int k = 0; k < 8; k++) begin
`ifdef CHAR_LINE_DRAWER_TRANSPARENT_EN
                    if (g[7-k])
`endif
                    exp_q.push_back({9'(96 + 8*c + k), 8'(112 + r), g[7-k] ? 3'b111 : 3'b000});
                end
            end
        end
    endtask

    // Raise dpt; returns #1 after the edge that samples it, with plaintext then scrambled.
    task automatic start_draw(input logic [127:0] txt);
        build_exp(txt);
        @(posedge clk); #1;
        plaintext = txt;
        dpt = 1'b1;
        @(posedge clk); #1;
        plaintext = ~txt;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (ddpt !== 1'b1 && cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (ddpt !== 1'b1) begin
            n_cmp++; n_mism++;
            $display("FAIL wait_done timeout: ddpt=%b after %0d cycles, want 1", ddpt, cyc);
        end
    endtask

    task automatic end_draw();
        dpt = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (ddpt !== 1'b0) begin n_mism++; $display("FAIL end_ddpt got %b want 0", ddpt); end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (ddpt !== 1'b0) begin n_mism++; $display("FAIL reset_ddpt got %b want 0", ddpt); end
        n_cmp++; if (busy !== 1'b0) begin n_mism++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (wr_en !== 1'b0) begin n_mism++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        n_cmp++; if ({wr_x, wr_y, wr_color} !== 20'd0) begin n_mism++; $display("FAIL reset_coords got %h want 0", {wr_x, wr_y, wr_color}); end
        n_cmp++; if (font_addr !== 12'h000) begin n_mism++; $display("FAIL reset_font_addr got %h want 000", font_addr); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_mism++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_spaces();
        int c;
        int w0 = n_wr;
        int b0 = wr_bad;
        start_draw({16{8'h20}});
        n_cmp++; if (busy !== 1'b1) begin n_mism++; $display("FAIL spaces_busy got %b want 1", busy); end
        wait_done(c);
        n_cmp++; if (c != 2560) begin n_mism++; $display("FAIL spaces_cycles got %0d want 2560", c); end
`ifdef CHAR_LINE_DRAWER_TRANSPARENT_EN
        n_cmp++; if (n_wr - w0 != 0) begin n_mism++; $display("FAIL spaces_writes got %0d want 0", n_wr - w0); end
`else
        n_cmp++; if (n_wr - w0 != 2048) begin n_mism++; $display("FAIL spaces_writes got %0d want 2048", n_wr - w0); end
        n_cmp++; if (first_w !== {9'd96, 8'd112, 3'd0}) begin n_mism++; $display("FAIL spaces_first got %h want %h", first_w, {9'd96, 8'd112, 3'd0}); end
        n_cmp++; if (last_w !== {9'd223, 8'd127, 3'd0}) begin n_mism++; $display("FAIL spaces_last got %h want %h", last_w, {9'd223, 8'd127, 3'd0}); end
`endif
        n_cmp++; if (wr_bad != b0) begin n_mism++; $display("FAIL spaces_pixels got %0d bad want 0", wr_bad - b0); end
        n_cmp++; if (exp_q.size() != 0) begin n_mism++; $display("FAIL spaces_missing got %0d left want 0", exp_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_mism++; $display("FAIL spaces_done_busy got %b want 0", busy); end
        end_draw();
    endtask

    task automatic test_glyph();
        int c;
        int n_exp;
        int w0 = n_wr;
        int b0 = wr_bad;
        int a0 = n_413;
        int r0 = n_row3;
        logic [127:0] txt = "A1B2C3D4E5F6G7H8";
        start_draw(txt);
        n_exp = exp_q.size();
        wait_done(c);
        n_cmp++; if (c != 2560) begin n_mism++; $display("FAIL glyph_cycles got %0d want 2560", c); end
        n_cmp++; if (n_413 == a0) begin n_mism++; $display("FAIL glyph_addr_413 got 0 cycles want >0"); end
        n_cmp++; if (row3_col[0] !== 3'b111) begin n_mism++; $display("FAIL glyph_x96 got %b want 111", row3_col[0]); end
        n_cmp++; if (row3_col[7] !== 3'b111) begin n_mism++; $display("FAIL glyph_x103 got %b want 111", row3_col[7]); end
`ifdef CHAR_LINE_DRAWER_TRANSPARENT_EN
        n_cmp++; if (n_row3 - r0 != 2) begin n_mism++; $display("FAIL glyph_row3_writes got %0d want 2", n_row3 - r0); end
`else
        n_cmp++; if (n_row3 - r0 != 8) begin n_mism++; $display("FAIL glyph_row3_writes got %0d want 8", n_row3 - r0); end
        for (int i = 1; i < 7; i++) begin
            n_cmp++; if (row3_col[i] !== 3'b000) begin n_mism++; $display("FAIL glyph_x%0d got %b want 000", 96 + i, row3_col[i]); end
        end
`endif
        n_cmp++; if (n_wr - w0 != n_exp) begin n_mism++; $display("FAIL glyph_writes got %0d want %0d", n_wr - w0, n_exp); end
        n_cmp++; if (wr_bad != b0) begin n_mism++; $display("FAIL glyph_pixels got %0d bad want 0", wr_bad - b0); end
        n_cmp++; if (exp_q.size() != 0) begin n_mism++; $display("FAIL glyph_missing got %0d left want 0", exp_q.size()); end
        end_draw();
    endtask

    task automatic test_all_a();
        int c;
        int w0 = n_wr;
        int b0 = wr_bad;
        start_draw({16{8'h41}});
        wait_done(c);
        n_cmp++; if (c != 2560) begin n_mism++; $display("FAIL all_a_cycles got %0d want 2560", c); end
`ifdef CHAR_LINE_DRAWER_TRANSPARENT_EN
        n_cmp++; if (n_wr - w0 != 640) begin n_mism++; $display("FAIL all_a_writes got %0d want 640", n_wr - w0); end
`else
        n_cmp++; if (n_wr - w0 != 2048) begin n_mism++; $display("FAIL all_a_writes got %0d want 2048", n_wr - w0); end
`endif
        n_cmp++; if (wr_bad != b0) begin n_mism++; $display("FAIL all_a_pixels got %0d bad want 0", wr_bad - b0); end
        end_draw();
    endtask

    task automatic test_stall();
        int cnt = 0;
        int hold = 0;
        int b0 = wr_bad;
        wr_ready = 1'b0;
        start_draw({8'h41, {15{8'h20}}});
        while (ddpt !== 1'b1 && cnt < 6000) begin
            @(posedge clk); #1;
            cnt++;
            if (wr_ready === 1'b0 && wr_en === 1'b1) begin
                hold++;
                n_cmp++;
                if ({wr_x, wr_y, wr_color} !== {9'd96, 8'd112, 3'b111}) begin
                    n_mism++;
                    $display("FAIL stall_hold%0d got (%0d,%0d,%b) want (96,112,111)", hold, wr_x, wr_y, wr_color);
                end
                if (hold == 6) wr_ready = 1'b1;
            end
        end
        wr_ready = 1'b1;
        n_cmp++; if (hold != 6) begin n_mism++; $display("FAIL stall_hold_cycles got %0d want 6", hold); end
        n_cmp++; if (cnt != 2565) begin n_mism++; $display("FAIL stall_cycles got %0d want 2565", cnt); end
        n_cmp++; if (wr_bad != b0) begin n_mism++; $display("FAIL stall_pixels got %0d bad want 0", wr_bad - b0); end
        end_draw();
    endtask

    task automatic test_handshake();
        int c;
        int w0;
        start_draw({16{8'h20}});
        wait_done(c);
        w0 = n_wr;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (ddpt !== 1'b1) begin n_mism++; $display("FAIL hs_hold_ddpt got %b want 1", ddpt); end
        n_cmp++; if (busy !== 1'b0) begin n_mism++; $display("FAIL hs_hold_busy got %b want 0", busy); end
        n_cmp++; if (n_wr != w0) begin n_mism++; $display("FAIL hs_no_redraw got %0d writes want 0", n_wr - w0); end
        end_draw();
        w0 = n_wr;
        start_draw({16{8'h20}});
        wait_done(c);
        n_cmp++; if (c != 2560) begin n_mism++; $display("FAIL hs_second_cycles got %0d want 2560", c); end
`ifdef CHAR_LINE_DRAWER_TRANSPARENT_EN
        n_cmp++; if (n_wr - w0 != 0) begin n_mism++; $display("FAIL hs_second_writes got %0d want 0", n_wr - w0); end
`else
        n_cmp++; if (n_wr - w0 != 2048) begin n_mism++; $display("FAIL hs_second_writes got %0d want 2048", n_wr - w0); end
`endif
        end_draw();
    endtask

    task automatic test_dpt_drop();
        int c;
        int hi = 0;
        int w0 = n_wr;
        start_draw({8'h41, {15{8'h20}}});
        dpt = 1'b0;
        wait_done(c);
        n_cmp++; if (c != 2560) begin n_mism++; $display("FAIL drop_cycles got %0d want 2560", c); end
`ifdef CHAR_LINE_DRAWER_TRANSPARENT_EN
        n_cmp++; if (n_wr - w0 != 40) begin n_mism++; $display("FAIL drop_writes got %0d want 40", n_wr - w0); end
`else
        n_cmp++; if (n_wr - w0 != 2048) begin n_mism++; $display("FAIL drop_writes got %0d want 2048", n_wr - w0); end
`endif
        repeat (5) begin
            @(posedge clk); #1;
            if (ddpt === 1'b1) hi++;
        end
        n_cmp++; if (hi != 0) begin n_mism++; $display("FAIL drop_ddpt_pulse got %0d extra cycles want 0", hi); end
    endtask

    task automatic test_reset_mid();
        int c;
        int w0;
        start_draw({16{8'h41}});
        repeat (7*160 + 40) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_mism++; $display("FAIL rst_mid_busy_before got %b want 1", busy); end
        #2;
        reset_n = 1'b0;
        dpt = 1'b0;
        #1;
        n_cmp++; if (wr_en !== 1'b0) begin n_mism++; $display("FAIL rst_mid_wr_en got %b want 0", wr_en); end
        n_cmp++; if (busy !== 1'b0) begin n_mism++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_cmp++; if (ddpt !== 1'b0) begin n_mism++; $display("FAIL rst_mid_ddpt got %b want 0", ddpt); end
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        w0 = n_wr;
        repeat (50) @(posedge clk);
        #1;
        n_cmp++; if (n_wr != w0) begin n_mism++; $display("FAIL rst_mid_no_writes got %0d want 0", n_wr - w0); end
        n_cmp++; if (busy !== 1'b0) begin n_mism++; $display("FAIL rst_mid_idle_busy got %b want 0", busy); end
        start_draw({16{8'h20}});
        wait_done(c);
        n_cmp++; if (c != 2560) begin n_mism++; $display("FAIL rst_mid_recover_cycles got %0d want 2560", c); end
        end_draw();
    endtask

    initial begin
        test_reset();
        test_spaces();
        test_glyph();
        test_all_a();
        test_stall();
        test_handshake();
        test_dpt_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
